icmp_chksum_calc: RTL

- Computes the 16-bit one's-complement sum over a byte range of the Tx DPRAM port B.
- Serves the ICMP echo-reply builder: that stage raises RunStart with a length and start address, waits for RunEnd, then inverts and writes back the result.
- Sits between the reply builder and the DPRAM port-B read path.
- Shares the port-B address bus with the builder by driving zero whenever idle.

---
 rtl/icmp_chksum_calc.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/icmp_chksum_calc.sv
// One's-complement byte-pair summer over DPRAM port B for the ICMP reply builder; CHKSUM_INVERT_EN stores the inverted sum.
// Done rises len+RD_LAT+2 edges after start (2 for len=0); oAddress is zero outside READ so it can be OR-shared.
module icmp_chksum_calc #(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 2
) (
    input  logic              iDm9000aClk,
    input  logic              iRst_n,
    input  logic              iRunStart,
    input  logic [15:0]       iLen,
    input  logic [ADDR_W-1:0] iStartAddr,
    output logic [ADDR_W-1:0] oAddress,
    input  logic [7:0]        iQ,
    output logic [15:0]       oChecksum,
    output logic              oRunEnd
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        DRAIN = 3'd2,
        FOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [15:0]         len_q;
    logic [15:0]         idx_q;
    logic [ADDR_W-1:0]   start_q;
    logic [16:0]         acc_q;
    logic [7:0]          hi_q;
    logic [RD_LAT-1:0]   tag_vld;
    logic [RD_LAT-1:0]   tag_odd;
    logic                issue;
    logic                pipe_empty;
    logic [15:0]         folded;

    function automatic logic [16:0] csum_add(input logic [16:0] acc, input logic [15:0] word);
        return {1'b0, acc[15:0]} + {1'b0, word} + {16'd0, acc[16]};
    endfunction

    assign pipe_empty = ~|tag_vld;
    assign folded     = acc_q[15:0] + {15'd0, acc_q[16]};

    always_comb begin
        state_nxt = state;
        oAddress  = '0;
        oRunEnd   = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                // Zero length still passes through DRAIN so both paths share the same done timing.
                if (iRunStart) begin
                    state_nxt = (iLen == 16'd0) ? DRAIN : READ;
                end
            end
            READ: begin
                oAddress = start_q + idx_q[ADDR_W-1:0];
                issue    = 1'b1;
                if (!iRunStart) begin
                    state_nxt = IDLE;
                end else if (idx_q == len_q - 16'd1) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!iRunStart) begin
                    state_nxt = IDLE;
                end else if (pipe_empty) begin
                    state_nxt = FOLD;
                end
            end
            FOLD: begin
                state_nxt = iRunStart ? DONE : IDLE;
            end
            DONE: begin
                oRunEnd = 1'b1;
                if (!iRunStart) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge iDm9000aClk) begin
        if (!iRst_n) begin
            state     <= IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            start_q   <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            tag_vld   <= '0;
            tag_odd   <= '0;
            oChecksum <= '0;
        end else begin
            state <= state_nxt;

            // Dropping the request flushes in-flight reads so an abort leaves nothing behind.
            if (!iRunStart) begin
                tag_vld <= '0;
                tag_odd <= '0;
            end else begin
                tag_vld[0] <= issue;
                tag_odd[0] <= idx_q[0];
                for (int i = 1; i < RD_LAT; i++) begin
                    tag_vld[i] <= tag_vld[i-1];
                    tag_odd[i] <= tag_odd[i-1];
                end
            end

            if (state == IDLE && iRunStart) begin
                len_q   <= iLen;
                start_q <= iStartAddr;
                idx_q   <= '0;
                acc_q   <= '0;
            end else begin
                if (state == READ) begin
                    idx_q <= idx_q + 16'd1;
                end
                if (iRunStart && tag_vld[RD_LAT-1]) begin
                    if (tag_odd[RD_LAT-1]) begin
                        acc_q <= csum_add(acc_q, {hi_q, iQ});
                    end else begin
                        hi_q <= iQ;
                    end
                end
                // The final capture lands before the pipe reads empty, so this never collides with it.
                if (state == DRAIN && iRunStart && pipe_empty && len_q[0]) begin
                    acc_q <= csum_add(acc_q, {hi_q, 8'h00});
                end
            end

            if (state == FOLD && iRunStart) begin
`ifdef CHKSUM_INVERT_EN
                oChecksum <= ~folded;
`else
                oChecksum <= folded;
`endif
            end
        end
    end

endmodule
